// File: rtl/leds7_scan_decoder.sv
// Receive-side decoder for a multiplexed 4-digit seven-segment bus; rebuilds BCD frames.
// Optional error counter port enabled by defining LEDS7_ERR_COUNT_EN.
module leds7_scan_decoder #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [6:0]  seg_in,
   input  logic [3:0]  dig_sel,
   output logic [15:0] digits_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        code_err,
   output logic [1:0]  err_digit
`ifdef LEDS7_ERR_COUNT_EN
   ,
   output logic [7:0]  err_count
`endif
);

   typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;

   state_t      state, state_nx;
   logic [6:0]  smp_seg;
   logic [3:0]  smp_sel;
   logic [7:0]  cnt, cnt_nx;
   logic [15:0] shadow;
   logic [3:0]  seen;
   logic        one_hot, same, decode, legal, load;
   logic [3:0]  nib;
   logic [1:0]  idx;

   // The incoming value is compared against the sample register, so the count
   // equals the number of consecutive identical samples including this edge.
   assign one_hot = (dig_sel != 4'd0) && ((dig_sel & (dig_sel - 4'd1)) == 4'd0);
   assign same    = (seg_in == smp_seg) && (dig_sel == smp_sel);
   assign load    = (&seen) && (!out_valid || out_ready);

   always_comb begin
      idx = 2'd0;
      case (dig_sel)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
   end

   always_comb begin
      legal = 1'b1;
      nib   = 4'd0;
      case (seg_in)
         7'b1111110: nib = 4'd0;
         7'b0110000: nib = 4'd1;
         7'b1101101: nib = 4'd2;
         7'b1111001: nib = 4'd3;
         7'b0110011: nib = 4'd4;
         7'b1011011: nib = 4'd5;
         7'b0011111: nib = 4'd6;
         7'b1110000: nib = 4'd7;
         7'b1111111: nib = 4'd8;
         7'b1110011: nib = 4'd9;
         default:    legal = 1'b0;
      endcase
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      decode   = 1'b0;
      case (state)
         IDLE: begin
            if (one_hot) begin
               state_nx = DWELL;
               cnt_nx   = 8'd1;
            end else begin
               cnt_nx = 8'd0;
            end
         end
         DWELL: begin
            if (!one_hot) begin
               state_nx = IDLE;
               cnt_nx   = 8'd0;
            end else if (!same) begin
               cnt_nx = 8'd1;
            end else if (cnt == 8'(STABLE_CYCLES - 1)) begin
               decode   = 1'b1;
               state_nx = DONE;
               cnt_nx   = 8'(STABLE_CYCLES);
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end
         DONE: begin
            if (!one_hot) begin
               state_nx = IDLE;
               cnt_nx   = 8'd0;
            end else if (!same) begin
               state_nx = DWELL;
               cnt_nx   = 8'd1;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         smp_seg    <= '0;
         smp_sel    <= '0;
         shadow     <= '0;
         seen       <= '0;
         digits_out <= '0;
         out_valid  <= 1'b0;
         code_err   <= 1'b0;
         err_digit  <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         smp_seg <= seg_in;
         smp_sel <= dig_sel;
         if (decode && legal) shadow[{idx, 2'b00} +: 4] <= nib;
         // A frame load reads shadow before this cycle's write; the new digit
         // is credited to the next frame.
         seen <= (load ? 4'd0 : seen) | ((decode && legal) ? (4'd1 << idx) : 4'd0);
         if (load) begin
            digits_out <= shadow;
            out_valid  <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         code_err <= decode && !legal;
         if (decode && !legal) err_digit <= idx;
      end
   end

`ifdef LEDS7_ERR_COUNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) err_count <= '0;
      else if (code_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_leds7_scan_decoder.sv
// Directed self-checking bench for leds7_scan_decoder with STABLE_CYCLES = 4.
module tb_leds7_scan_decoder;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [6:0]  seg_in = '0;
   logic [3:0]  dig_sel = '0;
   logic [15:0] digits_out;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        code_err;
   logic [1:0]  err_digit;
`ifdef LEDS7_ERR_COUNT_EN
   logic [7:0]  err_count;
`endif

   int checks = 0;
   int errors = 0;
   int beats = 0;
   int err_pulses = 0;
   logic [15:0] last_beat = '0;
   logic [1:0]  last_err_digit = '0;

   logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b0011111, 7'b1110000, 7'b1111111, 7'b1110011};

   leds7_scan_decoder #(.STABLE_CYCLES(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .seg_in     (seg_in),
      .dig_sel    (dig_sel),
      .digits_out (digits_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .code_err   (code_err),
      .err_digit  (err_digit)
`ifdef LEDS7_ERR_COUNT_EN
      ,
      .err_count  (err_count)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset_n) begin
         if (out_valid && out_ready) begin
            beats++;
            last_beat = digits_out;
         end
         if (code_err) begin
            err_pulses++;
            last_err_digit = err_digit;
         end
      end
   end

   task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n);
      seg_in  = s;
      dig_sel = d;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic scan(input logic [15:0] frame, input int n);
      logic [3:0] v;
      for (int i = 0; i < 4; i++) begin
         v = frame[i*4 +: 4];
         drive(pat[v], 4'b0001 << i, n);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      seg_in  = '0;
      dig_sel = '0;
      repeat (2) @(posedge clk);
      #1;
      reset_n    = 1'b1;
      beats      = 0;
      err_pulses = 0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (digits_out !== 16'h0000) begin errors++; $display("FAIL reset_digits: got %h want 0000", digits_out); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++;
      if (code_err !== 1'b0 || err_digit !== 2'd0) begin errors++; $display("FAIL reset_err: got %b/%0d want 0/0", code_err, err_digit); end
`ifdef LEDS7_ERR_COUNT_EN
      checks++;
      if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
`endif
      do_reset();
   endtask

   task automatic test_basic_frame();
      do_reset();
      out_ready = 1'b1;
      drive(pat[0], 4'b0001, 6);
      drive(pat[1], 4'b0010, 6);
      drive(pat[2], 4'b0100, 6);
      drive(pat[3], 4'b1000, 4);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early: valid got %b want 0", out_valid); end
      drive(pat[3], 4'b1000, 1);
      checks++;
      if (out_valid !== 1'b1 || digits_out !== 16'h3210) begin errors++; $display("FAIL basic_latency: got %b/%h want 1/3210", out_valid, digits_out); end
      drive(pat[3], 4'b1000, 1);
      drive(7'd0, 4'd0, 4);
      checks++;
      if (beats !== 1 || last_beat !== 16'h3210) begin errors++; $display("FAIL basic_frame: beats %0d data %h want 1/3210", beats, last_beat); end
      checks++;
      if (err_pulses !== 0 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_after: errs %0d valid %b want 0/0", err_pulses, out_valid); end
   endtask

   task automatic test_short_dwell();
      do_reset();
      drive(pat[0], 4'b0001, 6);
      drive(pat[1], 4'b0010, 3);
      drive(pat[2], 4'b0100, 6);
      drive(pat[3], 4'b1000, 6);
      drive(7'd0, 4'd0, 4);
      checks++;
      if (beats !== 0 || out_valid !== 1'b0) begin errors++; $display("FAIL short_dwell: beats %0d valid %b want 0/0", beats, out_valid); end
      drive(pat[1], 4'b0010, 6);
      drive(7'd0, 4'd0, 4);
      checks++;
      if (beats !== 1 || last_beat !== 16'h3210) begin errors++; $display("FAIL short_recover: beats %0d data %h want 1/3210", beats, last_beat); end
   endtask

   task automatic test_illegal_code();
      do_reset();
      drive(pat[0], 4'b0001, 6);
      drive(pat[1], 4'b0010, 6);
      drive(7'b0000001, 4'b0100, 3);
      checks++;
      if (code_err !== 1'b0) begin errors++; $display("FAIL illegal_early: code_err got %b want 0", code_err); end
      drive(7'b0000001, 4'b0100, 1);
      checks++;
      if (code_err !== 1'b1 || err_digit !== 2'd2) begin errors++; $display("FAIL illegal_pulse: got %b/%0d want 1/2", code_err, err_digit); end
      drive(7'b0000001, 4'b0100, 1);
      checks++;
      if (code_err !== 1'b0) begin errors++; $display("FAIL illegal_width: code_err got %b want 0", code_err); end
      drive(pat[3], 4'b1000, 6);
      drive(7'd0, 4'd0, 4);
      checks++;
      if (err_pulses !== 1 || last_err_digit !== 2'd2 || beats !== 0) begin
         errors++; $display("FAIL illegal_summary: errs %0d idx %0d beats %0d want 1/2/0", err_pulses, last_err_digit, beats);
      end
      drive(pat[2], 4'b0100, 6);
      drive(7'd0, 4'd0, 4);
      checks++;
      if (beats !== 1 || last_beat !== 16'h3210) begin errors++; $display("FAIL illegal_recover: beats %0d data %h want 1/3210", beats, last_beat); end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      scan(16'h3210, 6);
      drive(7'd0, 4'd0, 3);
      checks++;
      if (out_valid !== 1'b1 || digits_out !== 16'h3210) begin errors++; $display("FAIL bp_first: got %b/%h want 1/3210", out_valid, digits_out); end
      scan(16'h9876, 6);
      drive(7'd0, 4'd0, 3);
      checks++;
      if (out_valid !== 1'b1 || digits_out !== 16'h3210) begin errors++; $display("FAIL bp_hold: got %b/%h want 1/3210", out_valid, digits_out); end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checks++;
      if (beats !== 1 || last_beat !== 16'h3210) begin errors++; $display("FAIL bp_transfer: beats %0d data %h want 1/3210", beats, last_beat); end
      checks++;
      if (out_valid !== 1'b1 || digits_out !== 16'h9876) begin errors++; $display("FAIL bp_next: got %b/%h want 1/9876", out_valid, digits_out); end
      out_ready = 1'b1;
      drive(7'd0, 4'd0, 3);
      checks++;
      if (beats !== 2 || last_beat !== 16'h9876 || out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_drain: beats %0d data %h valid %b want 2/9876/0", beats, last_beat, out_valid);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b0;
      scan(16'h3210, 6);
      drive(pat[6], 4'b0001, 6);
      drive(pat[7], 4'b0010, 6);
      drive(pat[8], 4'b0100, 6);
      seg_in  = pat[9];
      dig_sel = 4'b1000;
      reset_n = 1'b0;
      #1;
      checks++;
      if (digits_out !== 16'h0000 || out_valid !== 1'b0 || code_err !== 1'b0) begin
         errors++; $display("FAIL mid_reset: got %h/%b/%b want 0000/0/0", digits_out, out_valid, code_err);
      end
      @(posedge clk);
      #1;
      reset_n    = 1'b1;
      out_ready  = 1'b1;
      beats      = 0;
      drive(pat[9], 4'b1000, 6);
      drive(7'd0, 4'd0, 4);
      checks++;
      if (beats !== 0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_partial: beats %0d valid %b want 0/0", beats, out_valid); end
      scan(16'h9876, 6);
      drive(7'd0, 4'd0, 4);
      checks++;
      if (beats !== 1 || last_beat !== 16'h9876) begin errors++; $display("FAIL mid_rescan: beats %0d data %h want 1/9876", beats, last_beat); end
   endtask

`ifdef LEDS7_ERR_COUNT_EN
   task automatic test_err_count();
      do_reset();
      for (int i = 0; i < 300; i++) begin
         drive(7'b0000001, 4'b0001, 4);
         drive(7'd0, 4'd0, 1);
      end
      drive(7'd0, 4'd0, 2);
      checks++;
      if (err_pulses !== 300) begin errors++; $display("FAIL errcnt_pulses: got %0d want 300", err_pulses); end
      checks++;
      if (err_count !== 8'd255) begin errors++; $display("FAIL errcnt_sat: got %0d want 255", err_count); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_frame();
      test_short_dwell();
      test_illegal_code();
      test_backpressure();
      test_reset_mid();
`ifdef LEDS7_ERR_COUNT_EN
      test_err_count();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/leds7_scan_decoder.md
# leds7_scan_decoder

Receive-side counterpart of the board's multiplexed 4-digit seven-segment drive. The block samples the shared `abcdefg` segment bus together with the one-hot digit select (LED0..LED3), waits for each digit's pattern to settle, and decodes it back to BCD. It assembles the four digits into a frame and presents it on a valid/ready output. It is used in loopback checking of the display path and as a hardware monitor beside the display driver.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical registered samples required before a digit is decoded. Legal range is 2..255.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `seg_in`  in  7  segment pattern, bit 6 = a … bit 0 = g, active-high.
- `dig_sel`  in  4  digit select, one-hot, bit n = LEDn. Zero means blanking.
- `digits_out`  out  16  frame: LED0 in [3:0], LED1 in [7:4], LED2 in [11:8], LED3 in [15:12].
- `out_valid`  out  1  `digits_out` holds an undelivered frame.
- `out_ready`  in  1  consumer accepts the frame.
- `code_err`  out  1  one-cycle pulse: a settled pattern is not a legal digit code.
- `err_digit`  out  2  index of the offending digit; updated with `code_err`.
- `err_count`  out  8  present only with `LEDS7_ERR_COUNT_EN`.

## Operation
- **Input stage**
  - `seg_in` and `dig_sel` are registered once into the sample register.
  - Each cycle the sample is compared with the previous sample.
- **Dwell FSM** (states IDLE, DWELL, DONE):
  - IDLE: the sample's `dig_sel` is zero or not one-hot.
    - Counter is held at 0.
    - Goes to DWELL when a one-hot sample arrives, with counter = 1.
  - DWELL: an identical sample increments the counter.
    - A changed one-hot sample restarts DWELL with counter = 1.
    - A non-one-hot sample goes to IDLE.
    - When the counter reaches `STABLE_CYCLES`, the pattern is decoded once and the FSM goes to DONE.
  - DONE: holds while the sample is unchanged, so only one decode happens per dwell.
    - A change goes to DWELL (one-hot) or IDLE (otherwise).
- **Decode table** (abcdefg):
  - 1111110 = 0, 0110000 = 1, 1101101 = 2, 1111001 = 3, 0110011 = 4
  - 1011011 = 5, 0011111 = 6, 1110000 = 7, 1111111 = 8, 1110011 = 9
  - Legal code: nibble is written to `shadow[idx]` and `seen[idx]` is set.
  - Any other code: `code_err` pulses, `err_digit` = idx, `seen` is unchanged.
- **Frame assembly**
  - When `seen` = 4'b1111 and the output slot is free (`!out_valid`, or `out_valid && out_ready` in the same cycle):
    - `digits_out` is loaded from `shadow`.
    - `out_valid` is set.
    - `seen` is cleared.
  - If the slot is not free, `seen` stays full and `shadow` keeps updating. The latest values are delivered when the slot frees.
- **Handshake**
  - A transfer happens on a cycle with `out_valid && out_ready`.
  - `out_valid` is cleared after the transfer unless a new frame loads in the same cycle.
  - `digits_out` is stable while `out_valid` is high and `out_ready` is low.
- A decode and a frame load in the same cycle are allowed. The load uses `shadow` before the write, and the new digit counts towards the next frame.

## Timing
- Reset values: `digits_out` = 0, `out_valid` = 0, `code_err` = 0, `err_digit` = 0, `err_count` = 0. FSM is in IDLE, `seen` = 0, `shadow` = 0.
- Asynchronous reset mid-dwell or mid-frame discards all partial state. All four digits must be recaptured.
- **Latency** for an input first present before edge 1 and held:
  - It is sampled at edge 1 and decoded at edge `STABLE_CYCLES`.
  - `code_err` is high for the cycle after edge `STABLE_CYCLES`.
  - `out_valid` rises after edge `STABLE_CYCLES`+1 following the fourth digit's capture.
- Minimum digit dwell for capture is `STABLE_CYCLES` cycles. Shorter dwells produce nothing.

## Configuration
- `LEDS7_ERR_COUNT_EN` defined:
  - Adds `err_count`, an 8-bit counter incremented on every `code_err` pulse.
  - It saturates at 255 and clears only on reset.
- `LEDS7_ERR_COUNT_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use `STABLE_CYCLES` = 4.
- **Basic frame:** LED0..LED3 carry 1111110, 0110000, 1101101, 1111001, 6 cycles each, `out_ready` = 1 → one `out_valid` beat with `digits_out` = 16'h3210 and no `code_err`.
- **Short dwell:** LED1 held for 3 cycles, then the select changes → no capture. After the remaining digits, no frame is produced until LED1 dwells ≥ 4 cycles.
- **Illegal code:** LED2 = 0000001 for 5 cycles → exactly one `code_err` pulse, `err_digit` = 2, `seen[2]` stays 0, no frame.
- **Backpressure:** `out_ready` = 0 while frames 3210 then 9876 complete → `digits_out` holds 16'h3210. Raise `out_ready` for one cycle → the next beat shows 16'h9876.
- **Reset mid-operation:** `reset_n` low after 3 of 4 digits are captured → all outputs are 0. A full new scan is required before `out_valid`.
- **Error counter:** with `LEDS7_ERR_COUNT_EN`, 300 illegal dwells → `err_count` = 255.
